// File: rtl/i2c_gain_slave.sv
// rtl/i2c_gain_slave.sv - I2C target owning the equalizer per-band gain registers
`timescale 1ns/1ps
module i2c_gain_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h6A,
    parameter int         NUM_REGS   = 10,
    parameter logic [7:0] RESET_GAIN = 8'd16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] gains_o,
    output logic                  gain_wr,
    output logic [7:0]            gain_idx,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    localparam logic [7:0] NREG8 = 8'(NUM_REGS);

    state_t     state;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] txreg;
    logic [7:0] ptr;
    logic       rw;
    logic       ack_bit;
    logic [7:0] gains [NUM_REGS];

    logic scl_rise, scl_fall, start_det, stop_det;
    logic ptr_ok;
    logic [7:0] ptr_inc, rd_cur, rd_nxt;

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & ~sda_s2 & sda_d;
    assign stop_det  = scl_s2 & scl_d & sda_s2 & ~sda_d;
    assign ptr_ok    = ptr < NREG8;
    assign ptr_inc   = ptr_ok ? ptr + 8'd1 : ptr;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign gains_o[8*g +: 8] = gains[g];
        end
    endgenerate

    // Out-of-range pointers read back as 8'hFF; rd_nxt serves the byte after a master ACK.
    always_comb begin
        rd_cur = 8'hFF;
        rd_nxt = 8'hFF;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ptr == 8'(k))     rd_cur = gains[k];
            if (ptr_inc == 8'(k)) rd_nxt = gains[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_d    <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_d    <= 1'b1;
            bit_cnt  <= 4'd0;
            shreg    <= 8'd0;
            txreg    <= 8'd0;
            ptr      <= 8'd0;
            rw       <= 1'b0;
            ack_bit  <= 1'b1;
            sda_oe   <= 1'b0;
            gain_wr  <= 1'b0;
            gain_idx <= 8'd0;
            busy     <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) gains[k] <= RESET_GAIN;
        end else begin
            scl_s1  <= scl_i;
            scl_s2  <= scl_s1;
            scl_d   <= scl_s2;
            sda_s1  <= sda_i;
            sda_s2  <= sda_s1;
            sda_d   <= sda_s2;
            gain_wr <= 1'b0;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == SLAVE_ADDR) begin
                                    rw     <= shreg[0];
                                    sda_oe <= 1'b1;
                                    state  <= ADDR_ACK;
                                end else begin
                                    state  <= IGNORE;
                                end
                            end else if (state == PTR) begin
                                ptr    <= shreg;
                                sda_oe <= 1'b1;
                                state  <= PTR_ACK;
                            end else begin
                                sda_oe <= ptr_ok;
                                state  <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                txreg  <= rd_cur;
                                sda_oe <= ~rd_cur[7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                    end
                    WDATA_ACK: begin
                        // Commit on the 9th rise so gains_o and gain_wr change together.
                        if (scl_rise && ptr_ok) begin
                            for (int k = 0; k < NUM_REGS; k++)
                                if (ptr == 8'(k)) gains[k] <= shreg;
                            gain_wr  <= 1'b1;
                            gain_idx <= ptr;
                            ptr      <= ptr + 8'd1;
                        end else if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                            state   <= RDATA_ACK;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            txreg  <= {txreg[6:0], 1'b1};
                            sda_oe <= ~txreg[6];
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            ack_bit <= sda_s2;
                        end else if (scl_fall) begin
                            if (!ack_bit) begin
                                ptr    <= ptr_inc;
                                txreg  <= rd_nxt;
                                sda_oe <= ~rd_nxt[7];
                                state  <= RDATA;
                            end else begin
                                state  <= IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
